// File: rtl/arbitro_registrador.sv
// Round-robin write controller for a shared negedge register with no enable/reset.
// Owns the register's d input: recirculates q, injects one winner's data for
// exactly one cycle, and forces INIT_VALUE while in reset/INIT.
module arbitro_registrador #(
  parameter int unsigned   N          = 8,
  parameter int unsigned   M          = 4,
  parameter logic [N-1:0]  INIT_VALUE = '0,
  localparam int unsigned  GW         = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M-1:0]    req,
  input  logic [M*N-1:0]  data_in,
  input  logic [N-1:0]    reg_q,
  output logic [N-1:0]    reg_d,
  output logic [M-1:0]    ack,
  output logic            busy,
  output logic [GW-1:0]   grant_id
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_WRITE = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [GW-1:0] r_ptr;
  logic [GW-1:0] r_grant_id;
  logic [N-1:0]  r_wdata;
  logic [M-1:0]  r_ack;
  logic          r_busy;

  logic [GW-1:0] w_idx;
  logic [GW-1:0] w_win;
  logic          w_found;
  logic [GW-1:0] w_ptr_nxt;
  logic [M-1:0]  w_ack_nxt;
  logic          w_busy_nxt;
  logic [N-1:0]  w_slice [M];

  // Split the flat data bus into per-requester words
  for (genvar g = 0; g < int'(M); g++) begin : g_slice
    assign w_slice[g] = data_in[g*N +: N];
  end

  // Round-robin pick: first asserted req scanning from the priority pointer
  always_comb begin
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      w_idx = GW'((32'(r_ptr) + i) % M);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Pointer moves just past the last winner, wrapping at M-1
  assign w_ptr_nxt = (r_grant_id == GW'(M - 1)) ? '0 : GW'(r_grant_id + 1'b1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  w_state_nxt = S_IDLE;
      S_IDLE:  if (w_found) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Output decode: register drive from current state, Moore outputs from next state
  always_comb begin
    reg_d      = reg_q;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_ack_nxt  = '0;
    if (w_state_nxt == S_ACK) w_ack_nxt = M'(1) << r_grant_id;
    case (r_state)
      S_INIT:  reg_d = INIT_VALUE;
      S_WRITE: reg_d = r_wdata;
      default: reg_d = reg_q;
    endcase
  end

  // Registered outputs, latched write data and priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= '0;
      r_busy     <= 1'b1;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_wdata    <= '0;
    end else begin
      r_ack  <= w_ack_nxt;
      r_busy <= w_busy_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_wdata    <= w_slice[w_win];
        r_grant_id <= w_win;
      end
      if (r_state == S_ACK) r_ptr <= w_ptr_nxt;
    end
  end

  assign ack      = r_ack;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_arbitro_registrador.sv
// Bench for arbitro_registrador: directed vector table, hand-written reset
// sequences and randomized traffic against a transaction-level model.
module tb_arbitro_registrador;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;
  localparam logic [7:0]  INIT_V = 8'hA5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [M-1:0]   req;
  logic [M*N-1:0] data_in;
  logic [N-1:0]   reg_q;
  logic [N-1:0]   reg_d;
  logic [M-1:0]   ack;
  logic           busy;
  logic [1:0]     grant_id;

  int n_total = 0;
  int n_bad   = 0;

  arbitro_registrador #(.N(N), .M(M), .INIT_VALUE(INIT_V)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .reg_q    (reg_q),
    .reg_d    (reg_d),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // The shared register: plain negedge D flip-flop bank
  always @(negedge clk) reg_q <= reg_d;

  // Transaction-level model: cycles left in the current write, winner, pointer
  int         m_left;
  int         m_w;
  int         m_ptr;
  bit         m_init;
  logic [7:0] m_reg;
  logic [3:0] m_ack;
  logic       m_busy;
  logic [1:0] m_grant;

  task automatic model_reset();
    m_left  = 0;
    m_w     = 0;
    m_ptr   = 0;
    m_init  = 1'b1;
    m_reg   = INIT_V;
    m_ack   = '0;
    m_busy  = 1'b1;
    m_grant = '0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (m_init) begin
      m_init = 1'b0;
      m_busy = 1'b0;
    end else if (m_left == 0) begin
      if (req != '0) begin
        m_w = -1;
        for (int i = 0; i < int'(M); i++) begin
          int idx;
          idx = (m_ptr + i) % int'(M);
          if (m_w < 0 && req[idx]) m_w = idx;
        end
        m_reg   = data_in[m_w*N +: N];
        m_grant = 2'(m_w);
        m_busy  = 1'b1;
        m_left  = 2;
      end
    end else if (m_left == 2) begin
      m_ack  = 4'(1 << m_w);
      m_left = 1;
    end else begin
      m_ack  = '0;
      m_busy = 1'b0;
      m_ptr  = (m_w + 1) % int'(M);
      m_left = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_ack",   32'(ack),      32'(m_ack));
    chk("model_busy",  32'(busy),     32'(m_busy));
    chk("model_grant", 32'(grant_id), 32'(m_grant));
    chk("model_reg_q", 32'(reg_q),    32'(m_reg));
  endtask

  // One clock: model advances at posedge, outputs checked just after negedge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  gid;
    logic [7:0]  q;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] r, logic [31:0] d, logic [3:0] a,
                              logic b, logic [1:0] g, logic [7:0] q);
    vec_t v;
    v.req = r; v.data = d; v.ack = a; v.busy = b; v.gid = g; v.q = q;
    return v;
  endfunction

  initial begin
    logic [31:0] dd;
    logic [31:0] ds;
    logic [31:0] dx;
    dd = 32'h44332211;
    ds = 32'h4433223C;
    dx = 32'h443322FF;

    // Round-robin with all four requesting: grants 0,1,2,3,0
    for (int g = 0; g < 5; g++) begin
      logic [7:0] q;
      logic [1:0] gi;
      gi = 2'(g % 4);
      q  = dd[gi*8 +: 8];
      tbl.push_back(mk(4'hF, dd, 4'h0,       1'b1, gi, q));
      tbl.push_back(mk(4'hF, dd, 4'(1 << gi), 1'b1, gi, q));
      tbl.push_back(mk(4'hF, dd, 4'h0,       1'b0, gi, q));
    end
    // Grant to requester 1 leaves ptr = 2, then req 0011 wraps to 0 then 1
    tbl.push_back(mk(4'h2, dd, 4'h0, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(4'h2, dd, 4'h2, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(4'h3, dd, 4'h0, 1'b0, 2'd1, 8'h22));
    tbl.push_back(mk(4'h3, dd, 4'h0, 1'b1, 2'd0, 8'h11));
    tbl.push_back(mk(4'h3, dd, 4'h1, 1'b1, 2'd0, 8'h11));
    tbl.push_back(mk(4'h3, dd, 4'h0, 1'b0, 2'd0, 8'h11));
    tbl.push_back(mk(4'h3, dd, 4'h0, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(4'h3, dd, 4'h2, 1'b1, 2'd1, 8'h22));
    tbl.push_back(mk(4'h0, dd, 4'h0, 1'b0, 2'd1, 8'h22));
    // Single write of 3C; data changed to FF during WRITE must be ignored
    tbl.push_back(mk(4'h1, ds, 4'h0, 1'b1, 2'd0, 8'h3C));
    tbl.push_back(mk(4'h1, dx, 4'h1, 1'b1, 2'd0, 8'h3C));
    tbl.push_back(mk(4'h0, dx, 4'h0, 1'b0, 2'd0, 8'h3C));
    tbl.push_back(mk(4'h0, dx, 4'h0, 1'b0, 2'd0, 8'h3C));
    tbl.push_back(mk(4'h0, dx, 4'h0, 1'b0, 2'd0, 8'h3C));

    // Reset held three cycles
    rst_n   = 1'b0;
    req     = '0;
    data_in = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_reg_q", 32'(reg_q), 32'hA5);
      chk("rst_busy",  32'(busy),  32'd1);
      chk("rst_ack",   32'(ack),   32'd0);
    end
    rst_n = 1'b1;
    cyc();
    chk("post_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_reg_q", 32'(reg_q), 32'hA5);
    end

    // Directed vector table
    foreach (tbl[i]) begin
      req     = tbl[i].req;
      data_in = tbl[i].data;
      cyc();
      chk($sformatf("tbl%0d_ack", i),   32'(ack),      32'(tbl[i].ack));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),     32'(tbl[i].busy));
      chk($sformatf("tbl%0d_gid", i),   32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("tbl%0d_reg_q", i), 32'(reg_q),    32'(tbl[i].q));
    end

    // Reset asserted in the WRITE cycle before the register samples
    req     = 4'h1;
    data_in = 32'h4433225A;
    @(posedge clk);
    model_step();
    #1;
    rst_n = 1'b0;
    model_reset();
    req = '0;
    @(negedge clk);
    #1;
    check_model();
    chk("abort_reg_q", 32'(reg_q), 32'hA5);
    chk("abort_ack",   32'(ack),   32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("abort_hold_ack", 32'(ack), 32'd0);
    end
    rst_n   = 1'b1;
    req     = 4'h2;
    data_in = 32'h44337711;
    cyc();
    cyc();
    chk("after_abort_gid",   32'(grant_id), 32'd1);
    chk("after_abort_reg_q", 32'(reg_q),    32'h77);
    cyc();
    chk("after_abort_ack",   32'(ack),      32'h2);
    req = '0;
    cyc();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      if (rst_n && $urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else if (!rst_n) begin
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) req = '0;
      else                           req = 4'($urandom_range(0, 15));
      data_in = $urandom();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
